// File: rtl/maxpool_layer_if.sv
// Bundle between the ReLU stage (master) and the 2x2/stride-2 max-pooling stage (slave).
// Also carries the pooling FSM state so checkers can observe it directly.
interface maxpool_layer_if #(
    parameter int DATA_WIDTH = 69,
    parameter int IN_X       = 24,
    parameter int IN_Y       = 24,
    parameter int CH         = 8
);
    // relu_done is a level-valid: the pooling stage starts when it samples it high
    // in IDLE, aborts if it drops mid-pass, and needs it low for one cycle after DONE.
    // relu_result must stay stable for as long as pool_busy is high.
    logic                  relu_done;
    logic [DATA_WIDTH-1:0] relu_result [CH][IN_X][IN_Y];
    logic [DATA_WIDTH-1:0] pool_result [CH][IN_X/2][IN_Y/2];
    logic                  pool_busy;
    logic                  pool_done;
    logic [1:0]            state;

    modport master (
        output relu_done, relu_result,
        input  pool_result, pool_busy, pool_done, state
    );

    modport slave (
        input  relu_done, relu_result,
        output pool_result, pool_busy, pool_done, state
    );
endinterface

// File: rtl/maxpool_layer.sv
// Sequential 2x2/stride-2 max pooling: one output position per cycle for all
// channels in parallel, walking the output grid in raster order.
module maxpool_layer #(
    parameter int DATA_WIDTH = 69,
    parameter int IN_X       = 24,
    parameter int IN_Y       = 24,
    parameter int CH         = 8
) (
    input  logic           clk,
    input  logic           rst,
    maxpool_layer_if.slave bus
);
    localparam int OUT_X = IN_X / 2;
    localparam int OUT_Y = IN_Y / 2;
    localparam int RW    = (OUT_X > 1) ? $clog2(OUT_X) : 1;
    localparam int CW    = (OUT_Y > 1) ? $clog2(OUT_Y) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_X - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(OUT_Y - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POOL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [RW-1:0]         orow;
    logic [CW-1:0]         ocol;
    logic [RW:0]           row0;
    logic [RW:0]           row1;
    logic [CW:0]           col0;
    logic [CW:0]           col1;
    logic [DATA_WIDTH-1:0] win_max [CH];

    function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    assign row0      = {orow, 1'b0};
    assign row1      = {orow, 1'b1};
    assign col0      = {ocol, 1'b0};
    assign col1      = {ocol, 1'b1};
    assign bus.state = state_q;

    // Three comparators per channel: two pairwise maxima, then the maximum of those.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            win_max[c] = max2(max2(bus.relu_result[c][row0][col0], bus.relu_result[c][row0][col1]),
                              max2(bus.relu_result[c][row1][col0], bus.relu_result[c][row1][col1]));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            orow          <= '0;
            ocol          <= '0;
            bus.pool_busy <= 1'b0;
            bus.pool_done <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                for (int r = 0; r < OUT_X; r++) begin
                    for (int k = 0; k < OUT_Y; k++) begin
                        bus.pool_result[c][r][k] <= '0;
                    end
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.relu_done) begin
                        state_q       <= POOL;
                        orow          <= '0;
                        ocol          <= '0;
                        bus.pool_busy <= 1'b1;
                    end
                end
                POOL: begin
                    if (!bus.relu_done) begin
                        // Abort: drop the current position, keep what is already written.
                        state_q       <= IDLE;
                        bus.pool_busy <= 1'b0;
                    end else begin
                        for (int c = 0; c < CH; c++) begin
                            bus.pool_result[c][orow][ocol] <= win_max[c];
                        end
                        if (ocol == COL_LAST) begin
                            ocol <= '0;
                            if (orow == ROW_LAST) begin
                                state_q       <= DONE;
                                bus.pool_busy <= 1'b0;
                                bus.pool_done <= 1'b1;
                            end else begin
                                orow <= orow + 1'b1;
                            end
                        end else begin
                            ocol <= ocol + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!bus.relu_done) begin
                        state_q       <= IDLE;
                        bus.pool_done <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    bus.pool_busy <= 1'b0;
                    bus.pool_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool_layer.sv
// Bench for maxpool_layer: random and patterned feature maps compared against
// an array-based reference of the pooled output and the pass timing.
module tb_maxpool_layer;
    localparam int DW    = 69;
    localparam int IN_X  = 24;
    localparam int IN_Y  = 24;
    localparam int CH    = 8;
    localparam int OUT_X = IN_X / 2;
    localparam int OUT_Y = IN_Y / 2;
    localparam int NPOS  = OUT_X * OUT_Y;
    localparam int ST_IDLE = 0;
    localparam logic [DW-1:0] BIG = {1'b1, 63'd0, 5'd5};

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] img     [CH][IN_X][IN_Y];
    logic [DW-1:0] exp_out [CH][OUT_X][OUT_Y];

    maxpool_layer_if #(.DATA_WIDTH(DW), .IN_X(IN_X), .IN_Y(IN_Y), .CH(CH)) bus ();

    maxpool_layer #(.DATA_WIDTH(DW), .IN_X(IN_X), .IN_Y(IN_Y), .CH(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: window maxima straight from the input image
    function automatic logic [DW-1:0] win_ref(int c, int r, int k);
        logic [DW-1:0] m = '0;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
                if (img[c][2*r+dy][2*k+dx] > m) m = img[c][2*r+dy][2*k+dx];
        return m;
    endfunction

    // Positions 0..n-1 of a pass (raster order) take the current image's maxima
    task automatic model_commit(int n);
        for (int p = 0; p < n; p++)
            for (int c = 0; c < CH; c++)
                exp_out[c][p / OUT_Y][p % OUT_Y] = win_ref(c, p / OUT_Y, p % OUT_Y);
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < OUT_X; r++)
                for (int k = 0; k < OUT_Y; k++)
                    exp_out[c][r][k] = '0;
    endtask

    // Driver tasks
    task automatic drive_img();
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < IN_X; i++)
                for (int j = 0; j < IN_Y; j++)
                    bus.relu_result[c][i][j] = img[c][i][j];
    endtask

    task automatic rand_img();
        int mode;
        logic [95:0] w;
        mode = int'($urandom_range(0, 2));
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < IN_X; i++)
                for (int j = 0; j < IN_Y; j++) begin
                    w = {$urandom, $urandom, $urandom};
                    case (mode)
                        0: img[c][i][j] = w[DW-1:0];
                        1: img[c][i][j] = DW'($urandom_range(0, 3));
                        default: img[c][i][j] = {w[1:0], 64'd0, w[2:0]};
                    endcase
                end
        drive_img();
    endtask

    task automatic compare_all(input string tag);
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < OUT_X; r++)
                for (int k = 0; k < OUT_Y; k++)
                    check($sformatf("%s c%0d r%0d k%0d", tag, c, r, k),
                          bus.pool_result[c][r][k], exp_out[c][r][k]);
    endtask

    // Raise relu_done, then follow the pass until pool_done (bounded)
    task automatic run_full(input string tag);
        int cnt;
        bus.relu_done = 1'b1;
        tick();
        check({tag, " busy_after_start"}, DW'(bus.pool_busy), DW'(1));
        cnt = 0;
        while (!bus.pool_done && cnt < NPOS + 20) begin
            tick();
            cnt++;
            check($sformatf("%s busy_done cyc%0d", tag, cnt), DW'({bus.pool_busy, bus.pool_done}),
                  DW'((cnt == NPOS) ? 2'b01 : 2'b10));
        end
        check({tag, " done_latency"}, DW'(cnt), DW'(NPOS));
        model_commit(NPOS);
        compare_all(tag);
    endtask

    task automatic drop_and_check(input string tag);
        bus.relu_done = 1'b0;
        tick();
        check({tag, " done_cleared"}, DW'(bus.pool_done), DW'(0));
        check({tag, " busy_cleared"}, DW'(bus.pool_busy), DW'(0));
        check({tag, " idle"}, DW'(bus.state), DW'(ST_IDLE));
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int both_cnt;

        // Reset with random inputs
        rst = 1'b0;
        bus.relu_done = 1'($urandom_range(0, 1));
        rand_img();
        model_clear();
        tick();
        tick();
        check("rst busy", DW'(bus.pool_busy), DW'(0));
        check("rst done", DW'(bus.pool_done), DW'(0));
        check("rst state", DW'(bus.state), DW'(ST_IDLE));
        compare_all("rst");
        bus.relu_done = 1'b0;
        rst = 1'b1;
        tick();

        // Ramp
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < IN_X; i++)
                for (int j = 0; j < IN_Y; j++)
                    img[c][i][j] = DW'(c * 1000 + i * 24 + j);
        drive_img();
        run_full("ramp");
        check("ramp c3 r11 k11", bus.pool_result[3][11][11], DW'(3575));
        check("ramp c0 r0 k0", bus.pool_result[0][0][0], DW'(25));
        drop_and_check("ramp");

        // Maximum at each window corner, full-width values
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < IN_X; i++)
                for (int j = 0; j < IN_Y; j++)
                    img[c][i][j] = DW'(7);
        for (int c = 0; c < CH; c++) begin
            img[c][0][0]   = BIG;
            img[c][4][5]   = BIG;
            img[c][11][14] = BIG;
            img[c][23][23] = BIG;
        end
        drive_img();
        run_full("corner");
        check("corner tl", bus.pool_result[2][0][0], BIG);
        check("corner tr", bus.pool_result[5][2][2], BIG);
        check("corner bl", bus.pool_result[6][5][7], BIG);
        check("corner br", bus.pool_result[7][11][11], BIG);
        check("corner other", bus.pool_result[1][6][3], DW'(7));
        drop_and_check("corner");

        // Abort on the 50th POOL cycle: positions 0..48 written
        rand_img();
        bus.relu_done = 1'b1;
        tick();
        repeat (49) tick();
        bus.relu_done = 1'b0;
        tick();
        check("abort idle", DW'(bus.state), DW'(ST_IDLE));
        check("abort done", DW'(bus.pool_done), DW'(0));
        check("abort busy", DW'(bus.pool_busy), DW'(0));
        model_commit(49);
        compare_all("abort");
        run_full("restart");
        drop_and_check("restart");

        // Level hold: one long relu_done pulse gives exactly one pass
        rand_img();
        bus.relu_done = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        both_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.pool_busy) busy_cnt++;
            if (bus.pool_done) done_cnt++;
            if (bus.pool_busy && bus.pool_done) both_cnt++;
        end
        check("hold busy_cycles", DW'(busy_cnt), DW'(NPOS));
        check("hold done_cycles", DW'(done_cnt), DW'(400 - NPOS));
        check("hold overlap", DW'(both_cnt), DW'(0));
        check("hold done_high", DW'(bus.pool_done), DW'(1));
        model_commit(NPOS);
        compare_all("hold");
        drop_and_check("hold");

        // Reset in the middle of a pass
        rand_img();
        bus.relu_done = 1'b1;
        tick();
        repeat (69) tick();
        rst = 1'b0;
        tick();
        model_clear();
        check("midrst busy", DW'(bus.pool_busy), DW'(0));
        check("midrst done", DW'(bus.pool_done), DW'(0));
        check("midrst state", DW'(bus.state), DW'(ST_IDLE));
        compare_all("midrst");
        rst = 1'b1;
        bus.relu_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("midrst no_resume %0d", i), DW'(bus.pool_busy), DW'(0));
        end
        compare_all("midrst hold");
        rand_img();
        run_full("post_rst");
        drop_and_check("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/maxpool_layer.md
# maxpool_layer

Sequential 2x2/stride-2 max-pooling stage that reads the ReLU stage's registered feature maps once the ReLU stage signals `relu_done`. It reduces CH maps of IN_X x IN_Y to IN_X/2 x IN_Y/2. It computes one output position per cycle for all channels in parallel, which keeps comparator count at CH x 3 instead of a full-array combinational tree. It raises `pool_done` for the downstream fully-connected stage.

## Interface
Parameters:
- `DATA_WIDTH`, 69: bits per feature element (unsigned; post-ReLU values are non-negative)
- `IN_X`, 24: input rows; must be even
- `IN_Y`, 24: input columns; must be even
- `CH`, 8: number of feature maps

Ports (clock and reset first):
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge)
- `relu_done`  input  1  start/valid from ReLU stage; level signal
- `relu_result`  input  [CH][IN_X][IN_Y] x DATA_WIDTH  unpacked input maps; must be stable while `pool_busy`=1
- `pool_result`  output reg  [CH][IN_X/2][IN_Y/2] x DATA_WIDTH  pooled maps
- `pool_busy`  output reg  1  high while pooling is in progress
- `pool_done`  output reg  1  high while the results are complete and valid

## Operation
- States: IDLE, POOL, DONE. Row counter `orow` (0..IN_X/2-1) and column counter `ocol` (0..IN_Y/2-1), each sized $clog2 with a minimum of 1 bit.
- IDLE: when `relu_done`=1, go to POOL with `orow`=`ocol`=0 and `pool_busy`<=1. Otherwise hold.
- POOL, each cycle, for every channel c: `pool_result[c][orow][ocol]` <= unsigned max of `relu_result[c][2r][2k]`, `[2r][2k+1]`, `[2r+1][2k]`, `[2r+1][2k+1]`, where r=`orow` and k=`ocol`.
  - Comparison is unsigned at full DATA_WIDTH. There is no truncation or saturation. Ties yield the equal value.
  - Raster order: `ocol` increments every cycle. On wrap from IN_Y/2-1 to 0, `orow` increments.
  - After writing the last position (IN_X/2-1, IN_Y/2-1), go to DONE with `pool_busy`<=0 and `pool_done`<=1.
- Abort: if `relu_done`=0 is sampled in POOL, the current position is not written. The block goes to IDLE with `pool_busy`<=0 and `pool_done` stays 0. Positions already written are retained. The counters reset on the next start.
- DONE: hold `pool_done`=1 and all results while `relu_done`=1. When `relu_done`=0, go to IDLE with `pool_done`<=0. A single long `relu_done` pulse therefore produces exactly one pooling pass.
- `pool_result` is not cleared on start; every position is overwritten during a full pass.

## Timing
- Reset (`rst`=0 at a rising edge): state=IDLE, `orow`=`ocol`=0, `pool_busy`=0, `pool_done`=0, every `pool_result` element=0. Reset has priority over all other conditions, including mid-POOL and DONE.
- Latency:
  - Edge E0 samples `relu_done`=1 in IDLE.
  - Edges E1..E(N), with N=(IN_X/2)*(IN_Y/2)=144 by default, each write one position.
  - `pool_done` is high after edge E(N), i.e. N cycles after the start edge. `pool_busy` is high from after E0 through E(N-1).
- Output position (r,k) is written at edge E(1 + r*IN_Y/2 + k).
- `pool_busy` and `pool_done` are never high simultaneously.
- Minimum restart: `relu_done` must be low for at least 1 sampled cycle after DONE before the next start is accepted.

## Test plan
- Reset: drive `rst`=0 for 2 cycles with random inputs. All outputs must be 0, `pool_busy`=0, `pool_done`=0.
- Ramp: set `relu_result[c][i][j]` = c*1000 + i*24 + j and hold `relu_done`=1.
  - `pool_done` must rise exactly 144 cycles after the start edge.
  - `pool_result[c][r][k]` must equal c*1000 + (2r+1)*24 + 2k+1; for example, channel 3, (11,11) = 3575.
- Max at each window corner: place 2^68+5 at the top-left, top-right, bottom-left and bottom-right corner of different windows, with all other elements 7.
  - Each of those windows must yield 2^68+5 (full-width unsigned compare); all other windows must yield 7.
- Abort: drop `relu_done` on the 50th POOL cycle.
  - The block must be in IDLE on the next cycle, with `pool_done`=0 and positions 0..48 written.
  - A restart must complete a full 144-cycle pass.
- Level hold: keep `relu_done`=1 for 400 cycles. Exactly one pass must occur, and `pool_done` must stay 1 until `relu_done` falls, then go to 0 one cycle later.
- Reset mid-POOL: assert `rst`=0 at POOL cycle 70. All outputs must clear the next cycle, and no pass may resume until `relu_done` is sampled high in IDLE.
